// File: rtl/jtroadf_gfx_pkg.sv
// Shared types and constants for the scroll-layer graphics ROM slot.
// The cache-entry struct backs both the single-entry and JTROADF_SLOT_CACHE_EN builds.
package jtroadf_gfx_pkg;

    localparam int SDRAM_AW  = 22;
    localparam int BURST_LEN = 2;
    localparam int ENTRY_AW  = 14;   // widest requester address an entry can hold

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        DATA0,
        DATA1
    } state_t;

    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [31:0]         data;
        logic                valid;
    } cache_entry_t;

endpackage

// File: rtl/jtroadf_slot_cache.sv
// Entry storage, hit compare and round-robin replacement pointer for the ROM slot.
// With one entry this is simply the cached-address/valid register of the slot.
module jtroadf_slot_cache
    import jtroadf_gfx_pkg::*;
#(
    parameter int AW      = 14,
    parameter int ENTRIES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] lookup_addr,
    input  logic          fill_start,
    input  logic          fill_en,
    input  logic [AW-1:0] fill_addr,
    input  logic [31:0]   fill_data,
    output logic          hit,
    output logic [31:0]   hit_data
);

    localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [PW-1:0]             ptr_reg;
    logic [ENTRIES-1:0]        match;
    logic [ENTRIES-1:0][31:0]  entry_data;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            cache_entry_t entry_reg;

            // The victim is invalidated when its refill starts, so a half-written
            // burst can never be reported as a hit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (ptr_reg == PW'(gi)) begin
                    if (fill_en) begin
                        entry_reg <= '{addr: ENTRY_AW'(fill_addr), data: fill_data, valid: 1'b1};
                    end else if (fill_start) begin
                        entry_reg.valid <= 1'b0;
                    end
                end
            end

            assign match[gi]      = entry_reg.valid && (entry_reg.addr == ENTRY_AW'(lookup_addr));
            assign entry_data[gi] = entry_reg.data;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (fill_en && ENTRIES > 1) begin
            ptr_reg <= (ptr_reg == PW'(ENTRIES - 1)) ? '0 : ptr_reg + PW'(1);
        end
    end

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (match[i]) begin
                hit      = 1'b1;
                hit_data = entry_data[i];
            end
        end
    end

endmodule

// File: rtl/jtroadf_gfx_slot.sv
// SDRAM responder for the scroll tile layer's graphics ROM: 32-bit words fetched as two beats.
// Define JTROADF_SLOT_CACHE_EN for a two-entry round-robin cache instead of a single entry.
module jtroadf_gfx_slot
    import jtroadf_gfx_pkg::*;
#(
    parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0,
    parameter int                  AW     = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rom_cs,
    input  logic [AW-1:0]       rom_addr,
    output logic [31:0]         rom_data,
    output logic                rom_ok,
    output logic [SDRAM_AW-1:0] sdram_addr,
    output logic                sdram_req,
    input  logic                sdram_ack,
    input  logic                data_dst,
    input  logic [15:0]         sdram_din
);

`ifdef JTROADF_SLOT_CACHE_EN
    localparam int ENTRIES = 2;
`else
    localparam int ENTRIES = 1;
`endif

    state_t              state_reg, state_next;
    logic [AW-1:0]       addr_reg, addr_next;
    logic                req_reg, req_next;
    logic [SDRAM_AW-1:0] sdram_addr_reg, sdram_addr_next;
    logic [31:0]         data_reg, data_next;
    logic                fill_start, fill_en;
    logic                hit;
    logic [31:0]         hit_data;

    jtroadf_slot_cache #(
        .AW      (AW),
        .ENTRIES (ENTRIES)
    ) u_cache (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_addr (rom_addr),
        .fill_start  (fill_start),
        .fill_en     (fill_en),
        .fill_addr   (addr_reg),
        .fill_data   ({sdram_din, data_reg[15:0]}),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            req_reg        <= 1'b0;
            sdram_addr_reg <= '0;
            data_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            req_reg        <= req_next;
            sdram_addr_reg <= sdram_addr_next;
            data_reg       <= data_next;
        end
    end

    // Once a request is issued the burst always runs to completion; address
    // changes are only looked at again back in IDLE.
    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        req_next        = req_reg;
        sdram_addr_next = sdram_addr_reg;
        data_next       = data_reg;
        fill_start      = 1'b0;
        fill_en         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rom_cs && !hit) begin
                    addr_next       = rom_addr;
                    req_next        = 1'b1;
                    sdram_addr_next = OFFSET + SDRAM_AW'({rom_addr, 1'b0});
                    fill_start      = 1'b1;
                    state_next      = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    req_next   = 1'b0;
                    state_next = DATA0;
                end
            end
            DATA0: begin
                if (data_dst) begin
                    data_next[15:0] = sdram_din;
                    state_next      = DATA1;
                end
            end
            DATA1: begin
                if (data_dst) begin
                    data_next[31:16] = sdram_din;
                    fill_en          = 1'b1;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sdram_req  = req_reg;
    assign sdram_addr = sdram_addr_reg;
    assign rom_ok     = rom_cs & hit;
    assign rom_data   = hit ? hit_data : data_reg;

endmodule

// File: tb/tb_jtroadf_gfx_slot.sv
// Self-checking bench for jtroadf_gfx_slot with a scripted arbiter and scoreboard queues.
module tb_jtroadf_gfx_slot;

    localparam logic [21:0] OFFSET = 22'h10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rom_cs = 1'b0;
    logic [13:0] rom_addr = '0;
    logic [31:0] rom_data;
    logic        rom_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack = 1'b0;
    logic        data_dst = 1'b0;
    logic [15:0] sdram_din = '0;

    int errors = 0;
    int checks = 0;

    logic [21:0] addr_q[$];
    logic [31:0] data_q[$];

    jtroadf_gfx_slot #(.OFFSET(OFFSET), .AW(14)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .data_dst   (data_dst),
        .sdram_din  (sdram_din)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] map_addr(input logic [13:0] a);
        return OFFSET + {7'd0, a, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_req(input string name);
        logic [21:0] exp;
        int n;
        n = 0;
        while (sdram_req !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        exp = addr_q.pop_front();
        checks++;
        if (sdram_req !== 1'b1) begin
            errors++;
            $display("FAIL %s_req: sdram_req=%b after %0d cycles, required 1", name, sdram_req, n);
        end else if (sdram_addr !== exp) begin
            errors++;
            $display("FAIL %s_addr: sdram_addr=%h required %h", name, sdram_addr, exp);
        end
    endtask

    task automatic serve_burst(input string name, input logic [15:0] b0, input logic [15:0] b1,
                               input logic [13:0] addr_after, input logic cs_after);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        rom_addr  = addr_after;
        rom_cs    = cs_after;
        checks++;
        if (sdram_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_ack_drop: sdram_req=%b required 0", name, sdram_req);
        end
        tick();
        data_dst = 1'b1; sdram_din = b0;
        tick();
        data_dst = 1'b0;
        tick();
        data_dst = 1'b1; sdram_din = b1;
        tick();
        data_dst = 1'b0;
        data_q.push_back({b1, b0});
        $display("burst %s: beat0=%h beat1=%h", name, b0, b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (sdram_req !== 1'b0 || rom_ok !== 1'b0 || rom_data !== 32'h0 || sdram_addr !== 22'h0) begin
            errors++;
            $display("FAIL reset: req=%b ok=%b data=%h addr=%h required all zero",
                     sdram_req, rom_ok, rom_data, sdram_addr);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] exp;
        rom_cs   = 1'b1;
        rom_addr = 14'h0123;
        addr_q.push_back(map_addr(14'h0123));
        tick();
        checks++;
        if (sdram_req !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: sdram_req=%b one cycle after address, required 1", sdram_req);
        end
        expect_req("basic");
        serve_burst("basic", 16'hBEEF, 16'hDEAD, 14'h0123, 1'b1);
        exp = data_q.pop_front();
        checks++;
        if (rom_ok !== 1'b1 || rom_data !== exp) begin
            errors++;
            $display("FAIL basic_data: ok=%b data=%h required ok=1 data=%h", rom_ok, rom_data, exp);
        end
    endtask

    task automatic test_hold();
        int reqs, drops;
        reqs = 0; drops = 0;
        repeat (100) begin
            tick();
            if (sdram_req !== 1'b0) reqs++;
            if (rom_ok !== 1'b1) drops++;
        end
        checks++;
        if (reqs != 0) begin
            errors++;
            $display("FAIL hold_req: sdram_req high on %0d cycles, required 0", reqs);
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL hold_ok: rom_ok low on %0d cycles, required 0", drops);
        end
        data_dst = 1'b1; sdram_din = 16'hFFFF;
        tick();
        data_dst = 1'b0;
        checks++;
        if (rom_ok !== 1'b1 || rom_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL idle_dst: ok=%b data=%h required ok=1 data=deadbeef", rom_ok, rom_data);
        end
    endtask

    task automatic test_addr_change();
        logic [31:0] exp;
        rom_addr = 14'h0200;
        addr_q.push_back(map_addr(14'h0200));
        expect_req("chg_old");
        addr_q.push_back(map_addr(14'h0124));
        serve_burst("chg_old", 16'h1111, 16'h2222, 14'h0124, 1'b1);
        exp = data_q.pop_front();
        checks++;
        if (rom_ok !== 1'b0) begin
            errors++;
            $display("FAIL chg_ok_low: rom_ok=%b after stale burst, required 0", rom_ok);
        end
        checks++;
        if (rom_data !== exp) begin
            errors++;
            $display("FAIL chg_data_hold: rom_data=%h required %h", rom_data, exp);
        end
        expect_req("chg_new");
        serve_burst("chg_new", 16'h3333, 16'h4444, 14'h0124, 1'b1);
        exp = data_q.pop_front();
        checks++;
        if (rom_ok !== 1'b1 || rom_data !== exp) begin
            errors++;
            $display("FAIL chg_new_data: ok=%b data=%h required ok=1 data=%h", rom_ok, rom_data, exp);
        end
    endtask

    task automatic test_cs_low();
        logic [31:0] exp;
        int bad;
        bad = 0;
        rom_cs   = 1'b0;
        rom_addr = 14'h0400;
        repeat (8) begin
            tick();
            if (sdram_req !== 1'b0 || rom_ok !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL cs_low: req/ok high on %0d cycles, required 0", bad);
        end
        rom_cs = 1'b1;
        addr_q.push_back(map_addr(14'h0400));
        expect_req("cs");
        data_dst = 1'b1; sdram_din = 16'hFFFF;
        tick();
        data_dst = 1'b0;
        serve_burst("cs", 16'h8888, 16'h9999, 14'h0400, 1'b1);
        exp = data_q.pop_front();
        checks++;
        if (rom_ok !== 1'b1 || rom_data !== exp) begin
            errors++;
            $display("FAIL cs_data: ok=%b data=%h required ok=1 data=%h", rom_ok, rom_data, exp);
        end
    endtask

    task automatic test_cs_drop();
        logic [31:0] exp;
        int bad;
        bad = 0;
        rom_addr = 14'h0500;
        addr_q.push_back(map_addr(14'h0500));
        expect_req("drop");
        serve_burst("drop", 16'hAAAA, 16'hBBBB, 14'h0500, 1'b0);
        repeat (6) begin
            tick();
            if (sdram_req !== 1'b0 || rom_ok !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL drop_quiet: req/ok high on %0d cycles, required 0", bad);
        end
        rom_cs = 1'b1;
        #1;
        exp = data_q.pop_front();
        checks++;
        if (rom_ok !== 1'b1 || rom_data !== exp) begin
            errors++;
            $display("FAIL drop_data: ok=%b data=%h required ok=1 data=%h", rom_ok, rom_data, exp);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        rom_addr = 14'h0300;
        addr_q.push_back(map_addr(14'h0300));
        expect_req("rst");
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        tick();
        data_dst = 1'b1; sdram_din = 16'h5555;
        tick();
        data_dst = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sdram_req !== 1'b0 || rom_ok !== 1'b0 || rom_data !== 32'h0 || sdram_addr !== 22'h0) begin
            errors++;
            $display("FAIL rst_async: req=%b ok=%b data=%h addr=%h required all zero",
                     sdram_req, rom_ok, rom_data, sdram_addr);
        end
        tick();
        rst_n = 1'b1;
        addr_q.push_back(map_addr(14'h0300));
        tick();
        checks++;
        if (sdram_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_rerequest: sdram_req=%b after release, required 1", sdram_req);
        end
        expect_req("rst_new");
        serve_burst("rst_new", 16'h6666, 16'h7777, 14'h0300, 1'b1);
        exp = data_q.pop_front();
        checks++;
        if (rom_ok !== 1'b1 || rom_data !== exp) begin
            errors++;
            $display("FAIL rst_data: ok=%b data=%h required ok=1 data=%h", rom_ok, rom_data, exp);
        end
    endtask

`ifdef JTROADF_SLOT_CACHE_EN
    task automatic test_cache();
        logic [31:0] exp1, exp2, want;
        int bad, reqs;
        bad = 0; reqs = 0;
        rom_addr = 14'h0001;
        addr_q.push_back(map_addr(14'h0001));
        expect_req("c1");
        serve_burst("c1", 16'h0101, 16'h1010, 14'h0001, 1'b1);
        exp1 = data_q.pop_front();
        rom_addr = 14'h0002;
        addr_q.push_back(map_addr(14'h0002));
        expect_req("c2");
        serve_burst("c2", 16'h0202, 16'h2020, 14'h0002, 1'b1);
        exp2 = data_q.pop_front();
        for (int i = 0; i < 20; i++) begin
            rom_addr = (i % 2 == 0) ? 14'h0001 : 14'h0002;
            want     = (i % 2 == 0) ? exp1 : exp2;
            #1;
            if (rom_ok !== 1'b1 || rom_data !== want) bad++;
            tick();
            if (sdram_req !== 1'b0) reqs++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL cache_hit: %0d cycles without hit/data, required 0", bad);
        end
        checks++;
        if (reqs != 0) begin
            errors++;
            $display("FAIL cache_req: sdram_req high on %0d cycles, required 0", reqs);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_basic();
        test_hold();
        test_addr_change();
        test_cs_low();
        test_cs_drop();
        test_reset_mid();
`ifdef JTROADF_SLOT_CACHE_EN
        test_cache();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtroadf_gfx_slot.md
Name: jtroadf_gfx_slot

Overview:
- SDRAM responder for the tile scroll layer's graphics-ROM port.
- Accepts a 14-bit 32-bit-word address and returns the word with a valid flag (rom_data/rom_ok).
- Fetches the word from the SDRAM controller as two 16-bit beats.
- Sits between the scroll tile layer and the shared SDRAM arbiter channel used by the game core.

Parameters:
- OFFSET, 22'h0, SDRAM 16-bit-word base address of the tile ROM region.
- AW, 14, width of the requester address (32-bit word granularity).

Ports:
- clk  in  1  system clock (48 MHz); the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- rom_cs  in  1  requester enable; when low, no new fetches are started.
- rom_addr  in  AW  requested 32-bit word address.
- rom_data  out  32  returned word; beat0 in [15:0], beat1 in [31:16].
- rom_ok  out  1  rom_data is valid for the current rom_addr.
- sdram_addr  out  22  16-bit word address to the arbiter.
- sdram_req  out  1  fetch request; held until acknowledged.
- sdram_ack  in  1  one-cycle pulse: arbiter accepted the request.
- data_dst  in  1  one-cycle pulse per returned beat for this slot.
- sdram_din  in  16  beat data, valid with data_dst.

Behaviour:
- Reset (async assert, sync release): state=IDLE; rom_ok=0, rom_data=0, sdram_req=0, sdram_addr=0, beat counter=0, cached-address valid=0.
- Address mapping: sdram_addr = OFFSET + {rom_addr, 1'b0}, computed modulo 2^22. Beat0 comes from the even word, beat1 from the odd word (burst of 2).
- rom_ok = rom_cs & valid & (rom_addr == cached address). This is combinational on the compare and registered on valid and the cached address. rom_ok falls in the same cycle rom_addr changes.
- FSM states:
  - IDLE: if rom_cs & (~valid | addr mismatch), latch the request address, drive sdram_req=1 and sdram_addr, clear valid, go to WAIT_ACK on the next edge.
  - WAIT_ACK: hold sdram_req and sdram_addr stable. On sdram_ack, drop sdram_req and go to DATA0.
  - DATA0: on data_dst, capture sdram_din into rom_data[15:0] and go to DATA1.
  - DATA1: on data_dst, capture sdram_din into rom_data[31:16], set valid=1 with cached address = latched address, go to IDLE.
- Latency: address change at cycle N gives sdram_req high at N+1. rom_ok is high the cycle after the second data_dst, if the address is unchanged.
- Address changes during WAIT_ACK/DATA0/DATA1: the in-flight burst always completes and the arbiter is never abandoned mid-burst. If the latched address ≠ rom_addr at completion, valid is still set for the latched address (rom_ok stays 0 by compare). IDLE then re-requests on the next cycle.
- rom_cs low mid-fetch: the fetch completes normally and no new request is issued afterwards.
- data_dst during IDLE/WAIT_ACK: ignored; there is no spurious capture.
- sdram_ack and data_dst in the same cycle: ack is processed; that data_dst is ignored (the arbiter guarantees ≥1 cycle between them).
- rom_data holds its last value when rom_ok=0. Beat0 of a new fetch may overwrite it before beat1 arrives; valid guards the result.

Optional Feature:
- JTROADF_SLOT_CACHE_EN defined: two-entry cache (address + 32-bit data + valid per entry) with round-robin replacement.
  - A hit on either entry gives rom_ok and rom_data combinationally in the same cycle, with no SDRAM request.
  - A miss fills the entry pointed to by the replacement pointer, and the pointer toggles on fill.
  - Reset clears both valid bits and the pointer.
- Macro undefined: single-entry behaviour as specified above.

Decomposition:
- Shared package jtroadf_gfx_pkg holds:
  - FSM state enum (IDLE, WAIT_ACK, DATA0, DATA1);
  - SDRAM_AW=22 and BURST_LEN=2 constants;
  - the cache-entry struct (addr, data, valid) used when the cache macro is enabled.
- One natural sub-module, jtroadf_slot_cache, holds the entry storage, hit compare and replacement pointer. It is instantiated with 1 or 2 entries depending on the macro.

Test Plan:
- Reset, rom_cs=1, rom_addr=14'h0123, OFFSET=22'h10000:
  - required: sdram_req=1 one cycle later with sdram_addr=22'h10246;
  - ack, then beats 16'hBEEF and 16'hDEAD: rom_data=32'hDEADBEEF and rom_ok=1 on the cycle after the second beat.
- Hold rom_addr=14'h0123 after the fill: no further sdram_req for 100 cycles and rom_ok stays 1.
- Change rom_addr to 14'h0124 between ack and beat0:
  - required: the old burst completes and rom_ok stays 0;
  - sdram_req re-asserts with 22'h10248; rom_ok=1 after the new burst.
- Assert rst_n=0 during DATA1:
  - required: sdram_req=0, rom_ok=0 and rom_data=0 immediately;
  - after release with the same address, a fresh request is issued.
- rom_cs=0 with an address change: sdram_req stays 0 and rom_ok=0. Raising rom_cs triggers the fetch.
- With JTROADF_SLOT_CACHE_EN, alternate rom_addr 14'h0001/14'h0002 after both fills: rom_ok=1 every cycle and zero sdram_req pulses.
